// File: rtl/char_motion.sv
// char_motion: per-frame character kinematics. Covers the horizontal walk, a velocity-based
// jump with gravity and terminal fall speed, coyote time, and an edge-triggered jump button.
// Optional feature macro: DOUBLE_JUMP_EN (one extra jump per airtime when defined).
module char_motion #(
    parameter int POS_W     = 12,
    parameter int VEL_W     = 8,
    parameter int SCREEN_W  = 1024,
    parameter int CHAR_LNG  = 19,
    parameter int SPAWN_X   = 204,
    parameter int GROUND_Y  = 689,
    parameter int MOVE_STEP = 5,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8,
    parameter int COYOTE_FR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic [1:0]       game_active,
    input  logic             respawn,
    input  logic             stepleft,
    input  logic             stepright,
    input  logic             stepjump,
    input  logic             on_ground,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             flip_h,
    output logic [1:0]       air_state,
    output logic             landed
);
    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISE     = 2'd1,
        FALL     = 2'd2
    } air_t;

    localparam int CW = $clog2(COYOTE_FR + 1);

    localparam logic [POS_W-1:0]        X_MIN    = POS_W'(CHAR_LNG + MOVE_STEP);
    localparam logic [POS_W-1:0]        X_MAX    = POS_W'(SCREEN_W - CHAR_LNG - MOVE_STEP);
    localparam logic [POS_W-1:0]        STEP     = POS_W'(MOVE_STEP);
    localparam logic [POS_W-1:0]        SPAWN_V  = POS_W'(SPAWN_X);
    localparam logic [POS_W-1:0]        GROUND_V = POS_W'(GROUND_Y);
    localparam logic [POS_W:0]          GROUND_W = (POS_W + 1)'(GROUND_Y);
    localparam logic signed [VEL_W-1:0] JUMP_V   = VEL_W'(JUMP_V0);
    localparam logic signed [VEL_W-1:0] GRAV_V   = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] MAX_V    = VEL_W'(MAX_FALL);
    localparam logic [CW-1:0]           COY_LIM  = CW'(COYOTE_FR);

    // Registered copies of every input
    logic       frame_tick_reg, respawn_reg, stepleft_reg, stepright_reg;
    logic       stepjump_reg, stepjump_prev, on_ground_reg;
    logic [1:0] game_active_reg;

    // Kinematic state and its next values
    air_t                    state, state_n;
    logic [POS_W-1:0]        x, x_n, y, y_n;
    logic signed [VEL_W-1:0] vy, vy_n;
    logic [CW-1:0]           coyote, coyote_n;
    logic                    jump_req, jump_req_n;
    logic                    flip_n, landed_n;
`ifdef DOUBLE_JUMP_EN
    logic                    air_jump_used, air_jump_used_n;
`endif

    // Per-frame arithmetic helpers; vy is never negative, so its magnitude is a zero-extension
    logic                    jump_edge, active, frame_en, air_take;
    logic [POS_W-1:0]        vy_mag;
    logic signed [VEL_W-1:0] vy_dec, vy_inc, vy_fall;
    logic [POS_W:0]          y_sum;
    logic [CW-1:0]           coyote_inc;

    assign jump_edge  = stepjump_reg & ~stepjump_prev;
    assign active     = (game_active_reg == 2'd1);
    assign frame_en   = frame_tick_reg & active;
    assign vy_mag     = {{(POS_W - VEL_W){1'b0}}, vy};
    assign vy_dec     = vy - GRAV_V;
    assign vy_inc     = vy + GRAV_V;
    assign vy_fall    = (vy_inc > MAX_V) ? MAX_V : vy_inc;
    assign y_sum      = {1'b0, y} + {{(POS_W + 1 - VEL_W){1'b0}}, vy_fall};
    assign coyote_inc = coyote + CW'(1);
`ifdef DOUBLE_JUMP_EN
    assign air_take   = jump_req & ~air_jump_used;
`else
    assign air_take   = 1'b0;
`endif

    // Register inputs once; stepjump_prev gives the rising-edge detector its history
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            frame_tick_reg  <= 1'b0;
            respawn_reg     <= 1'b0;
            stepleft_reg    <= 1'b0;
            stepright_reg   <= 1'b0;
            stepjump_reg    <= 1'b0;
            stepjump_prev   <= 1'b0;
            on_ground_reg   <= 1'b0;
            game_active_reg <= 2'd0;
        end else begin
            frame_tick_reg  <= frame_tick;
            respawn_reg     <= respawn;
            stepleft_reg    <= stepleft;
            stepright_reg   <= stepright;
            stepjump_reg    <= stepjump;
            stepjump_prev   <= stepjump_reg;
            on_ground_reg   <= on_ground;
            game_active_reg <= game_active;
        end
    end

    // Next-state logic: facing every clock, respawn first, then the per-frame update
    always_comb begin
        // NOTE: every next value takes its hold default first, so no path can infer a latch.
        state_n    = state;
        x_n        = x;
        y_n        = y;
        vy_n       = vy;
        coyote_n   = coyote;
        jump_req_n = jump_req | jump_edge;
        flip_n     = flip_h;
        landed_n   = 1'b0;
`ifdef DOUBLE_JUMP_EN
        air_jump_used_n = air_jump_used;
`endif
        if (active) begin
            if (stepleft_reg && !stepright_reg)
                flip_n = 1'b1;
            else if (stepright_reg && !stepleft_reg)
                flip_n = 1'b0;
        end

        if (respawn_reg) begin
            x_n        = SPAWN_V;
            y_n        = GROUND_V;
            state_n    = GROUNDED;
            vy_n       = '0;
            coyote_n   = '0;
            jump_req_n = 1'b0;
            landed_n   = (state == FALL);
        end else if (frame_en) begin
            // A pending request is used or dropped by this frame; only a fresh edge survives
            jump_req_n = jump_edge;

            if (stepleft_reg && !stepright_reg) begin
                if (x > X_MIN) x_n = x - STEP;
            end else if (stepright_reg && !stepleft_reg) begin
                if (x < X_MAX) x_n = x + STEP;
            end

            case (state)
                GROUNDED: begin
                    if (jump_req) begin
                        state_n  = RISE;
                        vy_n     = JUMP_V;
                        coyote_n = '0;
                    end else if (on_ground_reg) begin
                        coyote_n = '0;
                    end else if (y < GROUND_V) begin
                        coyote_n = coyote_inc;
                        if (coyote_inc == COY_LIM) begin
                            state_n  = FALL;
                            vy_n     = '0;
                            coyote_n = '0;
                        end
                    end
                end
                RISE: begin
                    if (air_take) begin
                        vy_n = JUMP_V;
`ifdef DOUBLE_JUMP_EN
                        air_jump_used_n = 1'b1;
`endif
                    end else if (y < vy_mag) begin
                        // Ceiling clamp: stop at row 0 instead of wrapping
                        y_n     = '0;
                        vy_n    = '0;
                        state_n = FALL;
                    end else begin
                        y_n = y - vy_mag;
                        if (vy_dec[VEL_W-1] || vy_dec == '0) begin
                            vy_n    = '0;
                            state_n = FALL;
                        end else begin
                            vy_n = vy_dec;
                        end
                    end
                end
                FALL: begin
                    if (air_take) begin
                        state_n = RISE;
                        vy_n    = JUMP_V;
`ifdef DOUBLE_JUMP_EN
                        air_jump_used_n = 1'b1;
`endif
                    end else if (y_sum >= GROUND_W) begin
                        y_n      = GROUND_V;
                        vy_n     = '0;
                        state_n  = GROUNDED;
                        landed_n = 1'b1;
                    end else if (on_ground_reg) begin
                        vy_n     = '0;
                        state_n  = GROUNDED;
                        landed_n = 1'b1;
                    end else begin
                        y_n  = y_sum[POS_W-1:0];
                        vy_n = vy_fall;
                    end
                end
                default: state_n = GROUNDED;
            endcase
        end
`ifdef DOUBLE_JUMP_EN
        if (state_n == GROUNDED) air_jump_used_n = 1'b0;
`endif
    end

    // Kinematic state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= GROUNDED;
            x        <= SPAWN_V;
            y        <= GROUND_V;
            vy       <= '0;
            coyote   <= '0;
            jump_req <= 1'b0;
            flip_h   <= 1'b0;
            landed   <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            air_jump_used <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            vy       <= vy_n;
            coyote   <= coyote_n;
            jump_req <= jump_req_n;
            flip_h   <= flip_n;
            landed   <= landed_n;
`ifdef DOUBLE_JUMP_EN
            air_jump_used <= air_jump_used_n;
`endif
        end
    end

    // Position outputs trail the internal state by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_x <= SPAWN_V;
            pos_y <= GROUND_V;
        end else begin
            pos_x <= x;
            pos_y <= y;
        end
    end

    assign air_state = state;

endmodule

// File: tb/tb_char_motion.sv
// tb_char_motion: directed self-checking bench for char_motion (default build; the
// DOUBLE_JUMP_EN section runs only when that macro is defined for the bench as well).
module tb_char_motion;
    logic        clk = 1'b0;
    logic        rst, frame_tick, respawn, stepleft, stepright, stepjump, on_ground;
    logic [1:0]  game_active;
    logic [11:0] pos_x, pos_y;
    logic        flip_h, landed;
    logic [1:0]  air_state;

    int checks = 0;
    int errors = 0;
    int landed_total = 0;

    char_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .respawn(respawn), .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
        .on_ground(on_ground), .pos_x(pos_x), .pos_y(pos_y), .flip_h(flip_h),
        .air_state(air_state), .landed(landed)
    );

    always #5 clk = ~clk;

    // Count clocks with landed high, sampled away from the active edge
    always @(negedge clk) if (landed === 1'b1) landed_total++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One frame: set levels, let them reach the input registers, pulse frame_tick, wait for pos
    task automatic do_frame(input logic l, input logic r, input logic j, input logic g);
        @(negedge clk);
        stepleft = l; stepright = r; stepjump = j; on_ground = g;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reference vertical model for frames with no jump request
    function automatic void model_step(inout int ey, inout int v, inout int st);
        if (st == 1) begin
            if (ey < v) begin
                ey = 0; v = 0; st = 2;
            end else begin
                ey -= v; v--;
                if (v <= 0) begin v = 0; st = 2; end
            end
        end else if (st == 2) begin
            v = (v + 1 > 8) ? 8 : v + 1;
            if (ey + v >= 689) begin ey = 689; v = 0; st = 0; end
            else ey += v;
        end
    endfunction

    // Airborne frames with on_ground low until the model reaches stop_st
    task automatic fly(inout int ey, inout int v, inout int st, input int stop_st,
                       input logic j, input string tag);
        int n = 0;
        while (st != stop_st && n < 60) begin
            model_step(ey, v, st);
            do_frame(1'b0, 1'b0, j, 1'b0);
            check({tag, "_y"}, pos_y, ey);
            check({tag, "_state"}, air_state, st);
            n++;
        end
        check({tag, "_end_state"}, st, stop_st);
    endtask

    typedef struct {
        logic l; logic r; logic j; logic g;
        int ex; int ey; int es; logic ef;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int ey, v, st, base;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 209, 689, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 214, 689, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 219, 689, 0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 224, 689, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 229, 689, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 234, 689, 0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 239, 689, 0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 244, 689, 0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 249, 689, 0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 254, 689, 0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 254, 689, 0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 254, 689, 0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 254, 689, 0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 249, 689, 0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 249, 689, 0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 249, 689, 0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 254, 689, 0, 1'b0};

        rst = 1'b1; frame_tick = 1'b0; game_active = 2'd1; respawn = 1'b0;
        stepleft = 1'b0; stepright = 1'b0; stepjump = 1'b0; on_ground = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_x", pos_x, 204);
        check("reset_y", pos_y, 689);
        check("reset_flip", flip_h, 0);
        check("reset_state", air_state, 0);
        check("reset_landed", landed, 0);
        rst = 1'b0;

        // Idle on the floor
        repeat (20) do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("idle_x", pos_x, 204);
        check("idle_y", pos_y, 689);
        check("idle_state", air_state, 0);
        check("idle_landed_pulses", landed_total, 0);

        // Horizontal walk and facing
        for (int i = 0; i < 17; i++) begin
            do_frame(vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].g);
            check($sformatf("vec%0d_x", i), pos_x, vecs[i].ex);
            check($sformatf("vec%0d_y", i), pos_y, vecs[i].ey);
            check($sformatf("vec%0d_state", i), air_state, vecs[i].es);
            check($sformatf("vec%0d_flip", i), flip_h, vecs[i].ef);
        end

        // Full jump from the floor, button held through landing
        base = landed_total;
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        ey = 689; v = 12; st = 1;
        check("jump_start_state", air_state, 1);
        check("jump_start_y", pos_y, 689);
        fly(ey, v, st, 2, 1'b1, "rise");
        check("apex_y", pos_y, 611);
        fly(ey, v, st, 0, 1'b1, "fall");
        check("land_y", pos_y, 689);
        check("land_x", pos_x, 254);
        check("landed_pulse_clks", landed_total - base, 1);
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b0, 1'b0, 1'b1, 1'b0);
            check("held_no_rejump_state", air_state, 0);
            check("held_no_rejump_y", pos_y, 689);
        end

        // Freeze mid-rise with game_active=2, then land on a ledge
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        ey = 689; v = 12; st = 1;
        check("jump2_state", air_state, 1);
        for (int i = 0; i < 3; i++) begin
            model_step(ey, v, st);
            do_frame(1'b0, 1'b0, 1'b1, 1'b0);
            check("jump2_y", pos_y, ey);
        end
        check("pre_freeze_y", pos_y, 656);
        game_active = 2'd2;
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b1, 1'b0, 1'b1, 1'b0);
            check("frozen_y", pos_y, 656);
            check("frozen_x", pos_x, 254);
            check("frozen_state", air_state, 1);
            check("frozen_flip", flip_h, 0);
        end
        game_active = 2'd1;
        model_step(ey, v, st);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("resume_y", pos_y, 647);
        fly(ey, v, st, 2, 1'b1, "rise2");
        base = landed_total;
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("ledge_land_state", air_state, 0);
        check("ledge_land_y", pos_y, 611);
        check("ledge_landed_clks", landed_total - base, 1);

        // Coyote window: jump on the third frame off the ledge is accepted
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("coyote1_state", air_state, 0);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("coyote2_state", air_state, 0);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("coyote3_jump_state", air_state, 1);
        check("coyote3_jump_y", pos_y, 611);
        ey = 611; v = 12; st = 1;
        fly(ey, v, st, 2, 1'b0, "rise3");
        check("apex3_y", pos_y, 533);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("ledge2_state", air_state, 0);
        check("ledge2_y", pos_y, 533);

        // Coyote window expires on frame 4; a jump on frame 5 comes too late
        for (int i = 0; i < 3; i++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b0);
            check("coyote_wait_state", air_state, 0);
        end
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("coyote4_state", air_state, 2);
        check("coyote4_y", pos_y, 533);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef DOUBLE_JUMP_EN
        ey = 533; v = 12; st = 1;
        check("air_jump_state", air_state, 1);
        check("air_jump_y", pos_y, 533);
        model_step(ey, v, st);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("air_jump_rise_y", pos_y, 521);
        model_step(ey, v, st);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("third_edge_y", pos_y, 510);
        check("third_edge_state", air_state, 1);
        fly(ey, v, st, 0, 1'b0, "dj_fall");
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        ey = 689; v = 12; st = 1;
        check("rearm_jump_state", air_state, 1);
        fly(ey, v, st, 2, 1'b0, "rearm_rise");
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        v = 12; st = 1;
        check("rearm_air_jump_state", air_state, 1);
        check("rearm_air_jump_y", pos_y, 611);
        fly(ey, v, st, 0, 1'b0, "rearm_fall");
`else
        model_step(ey, v, st);
        check("late_jump_state", air_state, 2);
        check("late_jump_y", pos_y, 534);
        fly(ey, v, st, 0, 1'b0, "late_fall");
        check("late_land_y", pos_y, 689);
`endif

        // Respawn mid-air
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("resp_jump_state", air_state, 1);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("resp_rise_y", pos_y, 677);
        @(negedge clk);
        respawn = 1'b1;
        @(negedge clk);
        respawn = 1'b0;
        repeat (3) @(negedge clk);
        check("respawn_x", pos_x, 204);
        check("respawn_y", pos_y, 689);
        check("respawn_state", air_state, 0);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("respawn_settled_state", air_state, 0);

        // Asynchronous reset mid-jump
        do_frame(1'b1, 1'b0, 1'b1, 1'b0);
        check("arst_jump_x", pos_x, 199);
        check("arst_jump_flip", flip_h, 1);
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("arst_rise_y", pos_y, 677);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_x", pos_x, 204);
        check("arst_y", pos_y, 689);
        check("arst_state", air_state, 0);
        check("arst_flip", flip_h, 0);
        @(negedge clk);
        rst = 1'b0;

        // Horizontal limits
        repeat (40) do_frame(1'b1, 1'b0, 1'b0, 1'b1);
        check("left_limit_x", pos_x, 24);
        check("left_limit_flip", flip_h, 1);
        repeat (200) do_frame(1'b0, 1'b1, 1'b0, 1'b1);
        check("right_limit_x", pos_x, 1004);
        check("right_limit_flip", flip_h, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
